instruction_fetch_unit: RTL and testbench

- Producer side of the instruction interface: fetches 16-bit instruction words from program memory and presents them, one at a time, to the instruction decoder and execute stage.
- Consumes the decoder's program_counter_increment decision plus a jump target to advance the program counter.
- Sits between program memory (req/ack read port) and the decoder (valid/ready issue port).
- One instruction in flight at a time.

---
 rtl/instruction_fetch_unit.sv | 96 +++++++++
 tb/tb_instruction_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads one 16-bit word at a time from program memory
// and hands it to the decoder, then advances pc by +1 or to a jump target.
module instruction_fetch_unit #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [15:0] instruction,
   output logic        instruction_valid,
   input  logic        instruction_ready,
   input  logic        program_counter_increment,
   input  logic [15:0] jump_target,
   output logic [15:0] pc,
   output logic        halted,
   output logic [15:0] retired_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } state_t;

   state_t      state_reg;
   logic [15:0] pc_reg;
   logic        mem_req_reg;
   logic [15:0] instruction_reg;
   logic        instruction_valid_reg;
   logic        halted_reg;
   logic [15:0] retired_count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg             <= IDLE;
         pc_reg                <= RESET_VECTOR;
         mem_req_reg           <= 1'b0;
         instruction_reg       <= 16'h0000;
         instruction_valid_reg <= 1'b0;
         halted_reg            <= 1'b1;
         retired_count_reg     <= 16'h0000;
      end else begin
         case (state_reg)
            IDLE: begin
               if (run) begin
                  state_reg   <= FETCH;
                  mem_req_reg <= 1'b1;
                  halted_reg  <= 1'b0;
               end
            end
            // run is deliberately not consulted here: a started fetch always completes.
            FETCH: begin
               if (mem_ack) begin
                  instruction_reg       <= mem_rdata;
                  instruction_valid_reg <= 1'b1;
                  mem_req_reg           <= 1'b0;
                  state_reg             <= ISSUE;
               end
            end
            ISSUE: begin
               if (instruction_ready) begin
                  pc_reg                <= program_counter_increment ? pc_reg + 16'd1 : jump_target;
                  retired_count_reg     <= retired_count_reg + 16'd1;
                  instruction_valid_reg <= 1'b0;
                  if (run) begin
                     state_reg   <= FETCH;
                     mem_req_reg <= 1'b1;
                  end else begin
                     state_reg  <= IDLE;
                     halted_reg <= 1'b1;
                  end
               end
            end
            default: begin
               state_reg   <= IDLE;
               mem_req_reg <= 1'b0;
               halted_reg  <= 1'b1;
            end
         endcase
      end
   end

   // pc is only updated on accept, so it already equals the address held during a fetch.
   assign mem_req           = mem_req_reg;
   assign mem_addr          = pc_reg;
   assign instruction       = instruction_reg;
   assign instruction_valid = instruction_valid_reg;
   assign pc                = pc_reg;
   assign halted            = halted_reg;
   assign retired_count     = retired_count_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed cycle table, reset corner case,
// then randomized traffic against a transaction-level reference model.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] instruction;
   logic        instruction_valid;
   logic        instruction_ready;
   logic        program_counter_increment;
   logic [15:0] jump_target;
   logic [15:0] pc;
   logic        halted;
   logic [15:0] retired_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instruction_fetch_unit #(.RESET_VECTOR(16'h0000)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .run                       (run),
      .mem_req                   (mem_req),
      .mem_addr                  (mem_addr),
      .mem_ack                   (mem_ack),
      .mem_rdata                 (mem_rdata),
      .instruction               (instruction),
      .instruction_valid         (instruction_valid),
      .instruction_ready         (instruction_ready),
      .program_counter_increment (program_counter_increment),
      .jump_target               (jump_target),
      .pc                        (pc),
      .halted                    (halted),
      .retired_count             (retired_count)
   );

   typedef struct packed {
      logic        run;
      logic        ack;
      logic [15:0] rdata;
      logic        ready;
      logic        inc;
      logic [15:0] jt;
      logic        e_req;
      logic [15:0] e_pc;
      logic        e_valid;
      logic [15:0] e_instr;
      logic        e_halted;
      logic [15:0] e_ret;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic a, input logic [15:0] d, input logic rdy,
                      input logic inc, input logic [15:0] jt, input logic ereq,
                      input logic [15:0] epc, input logic ev, input logic [15:0] ei,
                      input logic eh, input logic [15:0] eret);
      vecs.push_back({r, a, d, rdy, inc, jt, ereq, epc, ev, ei, eh, eret});
   endtask

   // Program memory contents: a fixed scramble of the address.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [31:0] p;
      p = a * 32'd40503 + 32'h1357;
      return p[15:0] ^ {a[7:0], a[15:8]};
   endfunction

   task automatic check_idle_after_reset(input string tag);
      chk({tag, " mem_req"}, {15'd0, mem_req}, 16'd0);
      chk({tag, " valid"}, {15'd0, instruction_valid}, 16'd0);
      chk({tag, " halted"}, {15'd0, halted}, 16'd1);
      chk({tag, " pc"}, pc, 16'h0000);
      chk({tag, " retired"}, retired_count, 16'd0);
   endtask

   // Reference model state (transaction level)
   logic [15:0] m_pc, m_ret, m_instr;
   logic        m_idle, m_req, m_valid;
   int          wait_cnt;

   initial begin
      reset = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
      instruction_ready = 1'b0; program_counter_increment = 1'b1; jump_target = 16'h0;
      @(negedge clk);
      @(negedge clk);
      check_idle_after_reset("reset");
      chk("reset instruction", instruction, 16'h0000);
      reset = 1'b0;

      // run, ack, rdata, ready, inc, jt | req, pc, valid, instr, halted, retired
      add(1,0,16'h0000,0,1,16'h0000, 1,16'h0000,0,16'h0000,0,16'd0);
      add(1,1,16'h1234,1,1,16'h0000, 0,16'h0000,1,16'h1234,0,16'd0);
      add(1,0,16'h0000,1,1,16'h0000, 1,16'h0001,0,16'h0000,0,16'd1);
      add(1,1,16'h2345,1,1,16'h0000, 0,16'h0001,1,16'h2345,0,16'd1);
      add(1,0,16'h0000,1,1,16'h0000, 1,16'h0002,0,16'h0000,0,16'd2);
      add(1,1,16'hA5A5,0,1,16'h0000, 0,16'h0002,1,16'hA5A5,0,16'd2);
      for (int i = 0; i < 5; i++)
         add(1,1,16'hFFFF,0,0,16'h1234, 0,16'h0002,1,16'hA5A5,0,16'd2);
      add(1,0,16'h0000,1,0,16'h0040, 1,16'h0040,0,16'h0000,0,16'd3);
      add(1,1,16'h0BAD,0,1,16'h0000, 0,16'h0040,1,16'h0BAD,0,16'd3);
      add(1,0,16'h0000,1,0,16'hFFFF, 1,16'hFFFF,0,16'h0000,0,16'd4);
      add(1,1,16'h7777,0,1,16'h0000, 0,16'hFFFF,1,16'h7777,0,16'd4);
      add(1,0,16'h0000,1,1,16'h0000, 1,16'h0000,0,16'h0000,0,16'd5);
      for (int i = 0; i < 3; i++)
         add(0,0,16'h0000,0,1,16'h0000, 1,16'h0000,0,16'h0000,0,16'd5);
      add(0,1,16'h1111,0,1,16'h0000, 0,16'h0000,1,16'h1111,0,16'd5);
      add(0,0,16'h0000,1,1,16'h0000, 0,16'h0001,0,16'h0000,1,16'd6);
      add(0,1,16'hBEEF,1,1,16'h0000, 0,16'h0001,0,16'h0000,1,16'd6);
      add(1,0,16'h0000,0,1,16'h0000, 1,16'h0001,0,16'h0000,0,16'd6);
      add(1,0,16'h0000,0,1,16'h0000, 1,16'h0001,0,16'h0000,0,16'd6);

      for (int i = 0; i < vecs.size(); i++) begin
         run = vecs[i].run; mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
         instruction_ready = vecs[i].ready; program_counter_increment = vecs[i].inc;
         jump_target = vecs[i].jt;
         @(negedge clk);
         chk($sformatf("vec%0d mem_req", i), {15'd0, mem_req}, {15'd0, vecs[i].e_req});
         chk($sformatf("vec%0d pc", i), pc, vecs[i].e_pc);
         if (vecs[i].e_req) chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_pc);
         chk($sformatf("vec%0d valid", i), {15'd0, instruction_valid}, {15'd0, vecs[i].e_valid});
         if (vecs[i].e_valid) chk($sformatf("vec%0d instruction", i), instruction, vecs[i].e_instr);
         chk($sformatf("vec%0d halted", i), {15'd0, halted}, {15'd0, vecs[i].e_halted});
         chk($sformatf("vec%0d retired", i), retired_count, vecs[i].e_ret);
      end

      // Reset while a fetch waits for its ack; ack arrives during and after reset.
      reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD; run = 1'b1;
      @(negedge clk);
      check_idle_after_reset("midfetch reset");
      chk("midfetch reset instruction", instruction, 16'h0000);
      reset = 1'b0; run = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hBEEF; instruction_ready = 1'b1;
      @(negedge clk);
      check_idle_after_reset("late ack");
      run = 1'b1; mem_ack = 1'b0;
      @(negedge clk);
      chk("restart mem_req", {15'd0, mem_req}, 16'd1);
      chk("restart mem_addr", mem_addr, 16'h0000);

      // Randomized phase, resynchronised with a reset.
      reset = 1'b1; run = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      m_pc = 16'h0; m_ret = 16'h0; m_instr = 16'h0;
      m_idle = 1'b1; m_req = 1'b0; m_valid = 1'b0; wait_cnt = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         logic r, a, rdy, inc, rst;
         logic [15:0] d, jt;
         chk("rnd halted", {15'd0, halted}, {15'd0, m_idle});
         chk("rnd mem_req", {15'd0, mem_req}, {15'd0, m_req});
         chk("rnd valid", {15'd0, instruction_valid}, {15'd0, m_valid});
         chk("rnd pc", pc, m_pc);
         chk("rnd retired", retired_count, m_ret);
         if (m_req) chk("rnd mem_addr", mem_addr, m_pc);
         if (m_valid) chk("rnd instruction", instruction, m_instr);

         rst = ($urandom_range(0, 299) == 0);
         r   = ($urandom_range(0, 99) < 85);
         rdy = ($urandom_range(0, 99) < 60);
         inc = ($urandom_range(0, 99) < 70);
         jt  = 16'($urandom);
         d   = 16'($urandom);
         if (cyc % 97 == 5) jt = 16'hFFFF;
         if (m_req) begin
            a = (wait_cnt == 0);
            if (a) d = mem_word(m_pc);
            else wait_cnt--;
         end else begin
            a = ($urandom_range(0, 3) == 0);
         end
         reset = rst; run = r; mem_ack = a; mem_rdata = d;
         instruction_ready = rdy; program_counter_increment = inc; jump_target = jt;

         if (rst) begin
            m_pc = 16'h0; m_ret = 16'h0; m_idle = 1'b1; m_req = 1'b0; m_valid = 1'b0;
         end else if (m_idle) begin
            if (r) begin
               m_idle = 1'b0; m_req = 1'b1; wait_cnt = $urandom_range(0, 3);
            end
         end else if (m_req) begin
            if (a) begin
               m_req = 1'b0; m_valid = 1'b1; m_instr = mem_word(m_pc);
            end
         end else if (m_valid && rdy) begin
            m_valid = 1'b0;
            m_ret   = m_ret + 16'd1;
            m_pc    = inc ? m_pc + 16'd1 : jt;
            if (r) begin
               m_req = 1'b1; wait_cnt = $urandom_range(0, 3);
            end else begin
               m_idle = 1'b1;
            end
         end
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
